// File: rtl/s_btn_debounce_multi.sv
// Multi-channel button conditioner: input polarity fix-up, 2-flop synchroniser,
// tick-sampled counter debounce, press/release pulses, long-press detection
// and optional auto-repeat, all sharing one sample-tick prescaler.
//
// Ports:
//   clk         system clock (single domain)
//   reset       asynchronous active-high reset
//   btn_in      raw asynchronous button inputs, one bit per channel
//   repeat_en   per-channel auto-repeat enable (synchronous)
//   btn_level   debounced level, 1 = pressed
//   btn_press   1-clk pulse on debounced press
//   btn_release 1-clk pulse on debounced release
//   btn_long    1-clk pulse when a hold reaches LONG_TICKS
//   btn_repeat  1-clk pulse every REPEAT_TICKS while long-held with repeat_en
module s_btn_debounce_multi #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned TICK_DIV       = 27000,
    parameter int unsigned STABLE_SAMPLES = 5,
    parameter int unsigned LONG_TICKS     = 1000,
    parameter int unsigned REPEAT_TICKS   = 100,
    parameter int unsigned ACTIVE_LOW     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_long,
    output logic [CHANNELS-1:0] btn_repeat
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = $clog2(STABLE_SAMPLES + 1);
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);
    localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_LONG = 2'd2
    } state_e;

    // Shared prescaler: tick_q is a registered 1-clk strobe every TICK_DIV clks.
    logic [CW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    always_comb begin
        div_d  = div_q + CW'(1);
        tick_d = 1'b0;
        if (div_q == CW'(TICK_DIV - 1)) begin
            div_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // Polarity normalisation followed by a 2-flop synchroniser.
    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = btn_in ^ {CHANNELS{(ACTIVE_LOW != 0)}};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SW-1:0] stab_q, stab_d;
        logic [HW-1:0] hold_q, hold_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        state_e        state_q, state_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        logic          rep_q, rep_d;
        logic          press_ev, release_ev;

        // Debounce and hold FSM share one evaluation so a release on the same
        // tick as a long/repeat threshold suppresses those pulses.
        always_comb begin
            stab_d     = stab_q;
            hold_d     = hold_q;
            rcnt_d     = rcnt_q;
            state_d    = state_q;
            level_d    = level_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            long_d     = 1'b0;
            rep_d      = 1'b0;
            press_ev   = 1'b0;
            release_ev = 1'b0;

            if (tick_q) begin
                if (sync2_q[i] == level_q) begin
                    stab_d = '0;
                end else if (stab_q == SW'(STABLE_SAMPLES - 1)) begin
                    level_d    = ~level_q;
                    stab_d     = '0;
                    press_ev   = ~level_q;
                    release_ev = level_q;
                end else begin
                    stab_d = stab_q + SW'(1);
                end
                press_d   = press_ev;
                release_d = release_ev;

                if (release_ev) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    rcnt_d  = '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (press_ev) begin
                                state_d = ST_HOLD;
                                hold_d  = '0;
                                rcnt_d  = '0;
                            end
                        end
                        ST_HOLD: begin
                            if (hold_q == HW'(LONG_TICKS - 1)) begin
                                // Hold counter parks at LONG_TICKS: one long per hold.
                                hold_d  = HW'(LONG_TICKS);
                                long_d  = 1'b1;
                                rcnt_d  = '0;
                                state_d = ST_LONG;
                            end else begin
                                hold_d = hold_q + HW'(1);
                            end
                        end
                        ST_LONG: begin
                            if (!repeat_en[i]) begin
                                rcnt_d = '0;
                            end else if (rcnt_q == RW'(REPEAT_TICKS - 1)) begin
                                rep_d  = 1'b1;
                                rcnt_d = '0;
                            end else begin
                                rcnt_d = rcnt_q + RW'(1);
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            hold_d  = '0;
                            rcnt_d  = '0;
                        end
                    endcase
                end
            end else if ((state_q == ST_LONG) && !repeat_en[i]) begin
                rcnt_d = '0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stab_q    <= '0;
                hold_q    <= '0;
                rcnt_q    <= '0;
                state_q   <= ST_IDLE;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                rep_q     <= 1'b0;
            end else begin
                stab_q    <= stab_d;
                hold_q    <= hold_d;
                rcnt_q    <= rcnt_d;
                state_q   <= state_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                rep_q     <= rep_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;
        assign btn_repeat[i]  = rep_q;
    end

endmodule

// File: tb/tb_s_btn_debounce_multi.sv
// Directed bench for s_btn_debounce_multi (2 channels, TICK_DIV=4,
// STABLE_SAMPLES=3, LONG_TICKS=5, REPEAT_TICKS=2) plus an ACTIVE_LOW=1
// instance whose inputs idle high.
module tb_s_btn_debounce_multi;

    logic       clk;
    logic       reset;
    logic [1:0] btn_in;
    logic [1:0] repeat_en;
    logic [1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

    logic [1:0] al_btn_in;
    logic [1:0] al_repeat_en;
    logic [1:0] al_level, al_press, al_release, al_long, al_repeat;

    int checks;
    int failures;
    int ec;
    int rel_cnt;
    int rel_before;
    int al_evt_cnt;

    s_btn_debounce_multi #(
        .CHANNELS(2), .TICK_DIV(4), .STABLE_SAMPLES(3),
        .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_long(btn_long), .btn_repeat(btn_repeat)
    );

    s_btn_debounce_multi #(
        .CHANNELS(2), .TICK_DIV(4), .STABLE_SAMPLES(3),
        .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .reset(reset), .btn_in(al_btn_in), .repeat_en(al_repeat_en),
        .btn_level(al_level), .btn_press(al_press), .btn_release(al_release),
        .btn_long(al_long), .btn_repeat(al_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        ec++;
        #1;
        if (btn_release[0]) rel_cnt++;
        if ((al_press != 2'b00) || (al_level != 2'b00)) al_evt_cnt++;
    endtask

    task automatic goto(input int n);
        while (ec < n) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, 32'h0);
    endtask

    initial begin
        checks = 0; failures = 0; ec = 0; rel_cnt = 0; al_evt_cnt = 0; rel_before = 0;
        reset = 1'b1;
        btn_in = 2'b00;
        repeat_en = 2'b01;
        al_btn_in = 2'b11;
        al_repeat_en = 2'b00;

        // 1. reset, then release; tick cadence
        repeat (3) step();
        chk_all_zero("rst_outputs");
        chk("rst_al_level", 32'(al_level), 32'h0);
        reset = 1'b0;
        ec = 0;
        goto(1); chk_all_zero("post_rst_e1");
        goto(3); chk("tick_e3", 32'(dut.tick_q), 32'h0);
        goto(4); chk("tick_e4", 32'(dut.tick_q), 32'h1);
        chk_all_zero("post_rst_e4");
        goto(5); chk("tick_e5", 32'(dut.tick_q), 32'h0);
        goto(6); btn_in = 2'b01;
        goto(8); chk("tick_e8", 32'(dut.tick_q), 32'h1);

        // 2. clean press on ch0
        goto(16); chk("level_e16", 32'(btn_level), 32'h0);
        goto(17); chk("level_e17", 32'(btn_level), 32'h1);
        chk("press_e17", 32'(btn_press), 32'h1);
        goto(18); chk("press_e18", 32'(btn_press), 32'h0);

        // 4a. long then repeats with repeat_en[0]=1
        goto(36); chk("long_e36", 32'(btn_long), 32'h0);
        goto(37); chk("long_e37", 32'(btn_long), 32'h1);
        goto(38); chk("long_e38", 32'(btn_long), 32'h0);
        goto(41); chk("rep_e41", 32'(btn_repeat), 32'h0);
        goto(45); chk("rep_e45", 32'(btn_repeat), 32'h1);
        goto(46); chk("rep_e46", 32'(btn_repeat), 32'h0);
        goto(53); chk("rep_e53", 32'(btn_repeat), 32'h1);
        goto(54); btn_in = 2'b00;
        goto(57); chk("level_e57", 32'(btn_level), 32'h1);
        goto(61); chk("rep_e61", 32'(btn_repeat), 32'h1);
        chk("rel_e61", 32'(btn_release), 32'h0);
        goto(65); chk("rel_e65", 32'(btn_release), 32'h1);
        chk("level_e65", 32'(btn_level), 32'h0);

        // 3. bounce on ch0: samples 1,1,0,1,1 then 1; ch1 presses on the same tick
        btn_in = 2'b01;
        goto(69); btn_in = 2'b01;
        goto(73); btn_in = 2'b00;
        goto(77); btn_in = 2'b11;
        goto(85); chk("bounce_level_e85", 32'(btn_level), 32'h0);
        goto(89); chk("bounce_press_e89", 32'(btn_press), 32'h3);
        chk("bounce_level_e89", 32'(btn_level), 32'h3);
        repeat_en = 2'b00;

        // 4b. long once, no repeats with repeat_en=0
        goto(109); chk("long_e109", 32'(btn_long), 32'h3);
        goto(113); chk("long_e113", 32'(btn_long), 32'h0);
        chk("rep_e113", 32'(btn_repeat), 32'h0);
        goto(117); chk("rep_e117", 32'(btn_repeat), 32'h0);
        goto(121); chk("rep_e121", 32'(btn_repeat), 32'h0);
        btn_in = 2'b00;
        goto(133); chk("rel_e133", 32'(btn_release), 32'h3);
        chk("level_e133", 32'(btn_level), 32'h0);
        btn_in = 2'b01;

        // 5. release lands on the long tick
        goto(145); chk("press_e145", 32'(btn_press), 32'h1);
        goto(153); btn_in = 2'b00;
        goto(164); chk("long_e164", 32'(btn_long), 32'h0);
        goto(165); chk("rel_e165", 32'(btn_release), 32'h1);
        chk("long_e165", 32'(btn_long), 32'h0);
        chk("level_e165", 32'(btn_level), 32'h0);
        btn_in = 2'b01;

        // 6. async reset mid-LONG with ch0 still held
        goto(177); chk("press_e177", 32'(btn_press), 32'h1);
        repeat_en = 2'b01;
        goto(197); chk("long_e197", 32'(btn_long), 32'h1);
        goto(198); chk("level_e198", 32'(btn_level), 32'h1);
        rel_before = rel_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        repeat (2) step();
        reset = 1'b0;
        ec = 0;
        goto(12); chk("rerst_level_e12", 32'(btn_level), 32'h0);
        chk("rerst_press_e12", 32'(btn_press), 32'h0);
        goto(13); chk("rerst_press_e13", 32'(btn_press), 32'h1);
        chk("rerst_level_e13", 32'(btn_level), 32'h1);
        goto(16); chk("rerst_no_release", 32'(rel_cnt), 32'(rel_before));

        // ACTIVE_LOW instance with inputs idle high never presses
        chk("al_level_end", 32'(al_level), 32'h0);
        chk("al_event_count", 32'(al_evt_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s_btn_debounce_multi.md
Name: s_btn_debounce_multi

Overview:
Parametrised multi-channel button conditioner with a shared sample-tick prescaler. Per channel it performs synchronisation, counter-based debounce, press/release edge pulses, long-press detection and optional auto-repeat. It sits between raw board buttons and control logic such as the SPI test controller and mode selectors. It generalises the single-button reset pulser to N channels with configurable timing and polarity.

Parameters:
CHANNELS, 4, number of independent button channels (>=1)
TICK_DIV, 27000, clk cycles per sample tick (>=2)
STABLE_SAMPLES, 5, consecutive differing samples needed to change debounced level (>=1)
LONG_TICKS, 1000, ticks a button must be held before btn_long fires (>=1)
REPEAT_TICKS, 100, ticks between btn_repeat pulses once long-press is reached (>=1)
ACTIVE_LOW, 0, 1 = raw inputs are active-low and are inverted at the input

Ports:
clk  in  1  system clock; the only clock domain
reset  in  1  asynchronous, active-high reset
btn_in  in  CHANNELS  raw asynchronous button inputs
repeat_en  in  CHANNELS  per-channel auto-repeat enable, synchronous to clk
btn_level  out  CHANNELS  debounced level (1 = pressed)
btn_press  out  CHANNELS  1-clk pulse on debounced press
btn_release  out  CHANNELS  1-clk pulse on debounced release
btn_long  out  CHANNELS  1-clk pulse when the hold reaches LONG_TICKS
btn_repeat  out  CHANNELS  1-clk pulse every REPEAT_TICKS while in the long state with repeat_en set

Behaviour:
- Reset: all outputs, synchroniser flops, prescaler, per-channel counters and FSMs clear to 0/IDLE immediately. No pulses are generated when reset is applied or released.
- Input path: XOR with ACTIVE_LOW, then a 2-flop synchroniser per channel (flops reset to 0). Let s[i] be the second flop output.
- Prescaler: counter 0..TICK_DIV-1 wraps. Registered tick is high for exactly 1 clk every TICK_DIV clks. The first tick is high TICK_DIV clks after reset deassertion. Counter width is $clog2(TICK_DIV).
- Debounce, per channel, evaluated only on tick cycles:
  - s[i]==btn_level[i]: stable counter clears.
  - s[i]!=btn_level[i] and counter==STABLE_SAMPLES-1: btn_level toggles, counter clears, btn_press or btn_release is asserted on the same edge.
  - Otherwise the counter increments.
  - All outputs are registered.
  - Worst-case latency from a stable raw change: 2 clk + STABLE_SAMPLES ticks.
- Hold FSM, per channel, states IDLE, HOLD, LONG:
  - IDLE -> HOLD on the press edge. The hold counter is 0 at entry.
  - HOLD: each tick increments the hold counter. When it reaches LONG_TICKS, btn_long pulses, state goes to LONG and the repeat counter clears.
  - LONG with repeat_en[i]=1: each tick increments the repeat counter. At REPEAT_TICKS, btn_repeat pulses and the counter clears.
  - LONG with repeat_en[i]=0: the repeat counter is held at 0 and no btn_repeat pulses occur.
  - Any state -> IDLE on the release edge; all counters clear.
- Simultaneous events: release wins over long/repeat on the same tick. That tick produces no btn_long and no btn_repeat.
- Channels are fully independent. Multiple channels may pulse in the same cycle.
- Counters saturate and never wrap. The hold counter stops at LONG_TICKS, so btn_long fires exactly once per hold.
- Reset mid-operation: the channel returns to IDLE with level 0. If the input is still pressed after reset, a fresh press is debounced normally and btn_release is never emitted for the aborted hold.

Test Plan:
(bench parameters: CHANNELS=2, TICK_DIV=4, STABLE_SAMPLES=3, LONG_TICKS=5, REPEAT_TICKS=2, ACTIVE_LOW=0)
1. Assert reset, then release with btn_in=0 -> all outputs stay 0; tick first high at clk 4 after release, then every 4 clks.
2. btn_in[0]=1 held -> btn_level[0] rises on the 3rd tick after s[0]=1; btn_press[0] high exactly 1 clk on that edge; channel 1 unaffected.
3. Bounce on btn_in[0] giving tick samples 1,1,0,1,1 -> no level change; a 3rd consecutive 1 then produces the press.
4. Hold ch0 with repeat_en[0]=1 -> btn_long 5 ticks after the press, then btn_repeat every 2 ticks. Repeat with repeat_en[0]=0 -> btn_long once, no repeats.
5. Release timed so the debounced release lands on the tick where btn_long would fire -> btn_release pulses, btn_long stays 0.
6. Async reset mid-LONG with btn_in[0] held -> outputs 0 within the same cycle. After deassertion, btn_press[0] reappears after 3 ticks and no btn_release is generated. With ACTIVE_LOW=1 and inputs idle high, no press ever occurs.
